// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, imem req/ack handshake, one-entry skid and IF/ID register.
// Optional IF_PERF_COUNTERS_EN adds fetched-instruction and bubble counters.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] next_pc,
   input  logic        redirect,
   input  logic        stall,
   output logic [31:0] pc_out,
   output logic [31:0] pc_add4,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        ifid_valid,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc_add4,
   output logic [31:0] ifid_instr
`ifdef IF_PERF_COUNTERS_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_bubbles
`endif
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_FLUSH = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   tgt_q, tgt_d;
   logic [XLEN-1:0]   skid_q, skid_d;
   logic              vld_q, vld_d;
   logic [XLEN-1:0]   ipc_q, ipc_d;
   logic [XLEN-1:0]   ipc4_q, ipc4_d;
   logic [XLEN-1:0]   instr_q, instr_d;

   assign pc_out       = pc_q;
   assign pc_add4      = pc_q + XLEN'(4);
   assign imem_addr    = pc_q;
   assign imem_req     = !rst && (state_q != S_HOLD);
   assign ifid_valid   = vld_q;
   assign ifid_pc      = ipc_q;
   assign ifid_pc_add4 = ipc4_q;
   assign ifid_instr   = instr_q;

   // Next-state and IF/ID load decode; redirect outranks stall everywhere.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      skid_d  = skid_q;
      vld_d   = vld_q;
      ipc_d   = ipc_q;
      ipc4_d  = ipc4_q;
      instr_d = instr_q;
      case (state_q)
         S_FETCH: begin
            if (redirect) begin
               vld_d   = 1'b0;
               instr_d = '0;
               if (imem_ack) begin
                  pc_d = next_pc;
               end else begin
                  tgt_d   = next_pc;
                  state_d = S_FLUSH;
               end
            end else if (imem_ack) begin
               if (!stall) begin
                  vld_d   = 1'b1;
                  ipc_d   = pc_q;
                  ipc4_d  = pc_add4;
                  instr_d = imem_rdata;
                  pc_d    = next_pc;
               end else begin
                  skid_d  = imem_rdata;
                  state_d = S_HOLD;
               end
            end else if (!stall) begin
               vld_d   = 1'b0;
               instr_d = '0;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               skid_d  = '0;
               vld_d   = 1'b0;
               instr_d = '0;
               pc_d    = next_pc;
               state_d = S_FETCH;
            end else if (!stall) begin
               vld_d   = 1'b1;
               ipc_d   = pc_q;
               ipc4_d  = pc_add4;
               instr_d = skid_q;
               pc_d    = next_pc;
               state_d = S_FETCH;
            end
         end
         S_FLUSH: begin
            // The old-address request must complete before the target is fetched.
            vld_d   = 1'b0;
            instr_d = '0;
            if (imem_ack) begin
               pc_d    = redirect ? next_pc : tgt_q;
               state_d = S_FETCH;
            end else if (redirect) begin
               tgt_d = next_pc;
            end
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         tgt_q   <= '0;
         skid_q  <= '0;
         vld_q   <= 1'b0;
         ipc_q   <= '0;
         ipc4_q  <= '0;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         skid_q  <= skid_d;
         vld_q   <= vld_d;
         ipc_q   <= ipc_d;
         ipc4_q  <= ipc4_d;
         instr_q <= instr_d;
      end
   end

`ifdef IF_PERF_COUNTERS_EN
   logic            fetch_load_c;
   logic            bubble_c;
   logic [XLEN-1:0] fetched_q;
   logic [XLEN-1:0] bubbles_q;

   // Bubble = IF/ID valid loaded 0 in a cycle the hazard unit is not stalling.
   always_comb begin
      fetch_load_c = 1'b0;
      bubble_c     = 1'b0;
      case (state_q)
         S_FETCH: begin
            fetch_load_c = !redirect && imem_ack && !stall;
            bubble_c     = !stall && (redirect || !imem_ack);
         end
         S_HOLD: begin
            fetch_load_c = !redirect && !stall;
            bubble_c     = redirect && !stall;
         end
         S_FLUSH: begin
            bubble_c = !stall;
         end
         default: begin
            fetch_load_c = 1'b0;
            bubble_c     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetched_q <= '0;
         bubbles_q <= '0;
      end else begin
         fetched_q <= fetched_q + XLEN'(fetch_load_c);
         bubbles_q <= bubbles_q + XLEN'(bubble_c);
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the pipelined MIPS core. Holds the program counter, drives the instruction-memory request/acknowledge handshake and loads the IF/ID pipeline register. It consumes the 32-bit next-PC chosen by the next-PC selector, which picks among PC+4, branch target, jump target and NOOP. It returns `pc_add4` to that selector. It absorbs hazard-unit stalls with a one-entry skid buffer and flushes on branch/jump redirects.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `next_pc` in 32: selected next PC; equals `pc_add4` when no redirect.
- `redirect` in 1: `next_pc` is a taken branch/jump target; flushes younger fetch.
- `stall` in 1: hazard unit holds IF/ID.
- `pc_out` out 32: current PC register.
- `pc_add4` out 32: `pc_out + 4`, combinational, modulo 2^32.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address.
- `imem_ack` in 1: memory accepts request; `imem_rdata` valid this cycle.
- `imem_rdata` in 32: instruction word.
- `ifid_valid` out 1: IF/ID holds a live instruction.
- `ifid_pc` out 32: PC of IF/ID instruction.
- `ifid_pc_add4` out 32: its PC+4.
- `ifid_instr` out 32: instruction word; 32'h0 (sll NOP) when invalid.

## Operation
- States: FETCH, HOLD, FLUSH. Reset → FETCH.
- Handshake: `imem_req`/`imem_addr` are combinational from state.
  - `imem_addr` = `pc_out` in every state.
  - While `imem_req`=1 and no ack, `imem_addr` must not change; a redirect is deferred.
  - `imem_req` is 0 during `rst` and in HOLD.
- FETCH (`imem_req`=1):
  - `redirect` & ack: discard data; `pc_out`←`next_pc`; `ifid_valid`←0; stay in FETCH.
  - `redirect` & !ack: target reg←`next_pc`; `ifid_valid`←0; go to FLUSH.
  - ack & !stall: IF/ID←{1, `pc_out`, `pc_add4`, `imem_rdata`}; `pc_out`←`next_pc`.
  - ack & stall: skid←`imem_rdata`; IF/ID unchanged; PC unchanged; go to HOLD.
  - !ack & !stall: `ifid_valid`←0 and `ifid_instr`←0 (bubble).
  - !ack & stall: IF/ID unchanged.
- HOLD (`imem_req`=0):
  - `redirect`: drop skid; `ifid_valid`←0; `pc_out`←`next_pc`; go to FETCH.
  - !stall: IF/ID←{1, `pc_out`, `pc_add4`, skid}; `pc_out`←`next_pc`; go to FETCH.
  - stall: hold.
- FLUSH (`imem_req`=1, old address):
  - `ifid_valid` held 0.
  - New `redirect` without ack: target reg←`next_pc`.
  - ack: discard data; `pc_out`←(`redirect` ? `next_pc` : target reg); go to FETCH.
  - `stall` is ignored.
- Priority: `rst` > `redirect` > `stall`.
- No alignment check; PC wraps 32'hFFFF_FFFC→0.

## Timing
- Reset values:
  - `pc_out`=`RESET_PC`.
  - `pc_add4`=`RESET_PC`+4.
  - `ifid_valid`=0; `ifid_pc`=0; `ifid_pc_add4`=0; `ifid_instr`=0.
  - `imem_req`=0.
  - Skid and target regs=0.
- First request is asserted the first cycle after `rst` deasserts.
- Latency: `imem_rdata` sampled at an ack edge appears on `ifid_instr` the next cycle.
- Throughput with zero-wait memory (ack same cycle as req): one instruction per cycle.
- Stall release from HOLD: instruction enters IF/ID on the release edge; the next request follows the cycle after.
- `rst` asserted mid-operation: immediate return to reset values; in-flight request abandoned; `imem_req` drops combinationally.

## Configuration
- `IF_PERF_COUNTERS_EN` defined:
  - Adds output `perf_fetched` [31:0]: increments on each IF/ID load with valid=1.
  - Adds output `perf_bubbles` [31:0]: increments each cycle `ifid_valid` is loaded 0 while not stalled.
  - Both counters reset to 0 and wrap at 2^32.
- Macro undefined: ports and counters absent.

## Test plan
- Reset then zero-wait memory, `next_pc`=`pc_add4`, RESET_PC=0:
  - `ifid_pc` sequence 0,4,8,12 on consecutive cycles.
  - `ifid_valid`=1 from cycle 2.
- Ack with `stall`=1 for 3 cycles, `imem_rdata`=32'h2008_0005:
  - FSM enters HOLD; `imem_req`=0; IF/ID unchanged.
  - On release, `ifid_instr`=32'h2008_0005 and `pc_out` advances by 4.
- `redirect`=1, `next_pc`=32'h0000_0040, with ack delayed 2 cycles:
  - `imem_addr` stays at old PC until ack; `ifid_valid`=0.
  - Next request is to 32'h40.
- Redirect and stall asserted the same cycle in HOLD: skid dropped, `ifid_valid`=0, `pc_out`=target.
- `rst` pulsed while in FLUSH: all outputs return to reset values; fetch resumes at RESET_PC.
- `IF_PERF_COUNTERS_EN`: 10 fetches with 2 no-ack bubbles → `perf_fetched`=10, `perf_bubbles`=2.
